// File: rtl/stack_sequencer.sv
// Call/return/interrupt stack sequencer: pushes and pops PC halves and CCR on a 16-bit stack.
// Optional guard: define STACK_GUARD_EN to block stack over/underflow and flag a sticky stack_err.
module stack_sequencer #(
  parameter logic [11:0] SP_RESET = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        call,
  input  logic        ret,
  input  logic        rti,
  input  logic        interrupt,
  input  logic [31:0] ret_pc,
  input  logic [2:0]  ccr_in,
  input  logic [15:0] pop_data,
  output logic [11:0] stack_addr,
  output logic [15:0] stack_wdata,
  output logic        stack_we,
  output logic        stack_re,
  output logic        fetch_pc_enable,
  output logic        pop_pc_low_sig,
  output logic        pop_pc_high_sig,
  output logic        pop_ccr_sig,
  output logic [2:0]  ccr_restore,
  output logic        vec_load,
  output logic        busy,
  output logic        stack_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PUSH_H = 3'd1;
  localparam logic [2:0] S_PUSH_L = 3'd2;
  localparam logic [2:0] S_PUSH_C = 3'd3;
  localparam logic [2:0] S_VECTOR = 3'd4;
  localparam logic [2:0] S_POP_C  = 3'd5;
  localparam logic [2:0] S_POP_L  = 3'd6;
  localparam logic [2:0] S_POP_H  = 3'd7;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [11:0] r_sp;
  logic        r_pend;
  logic        r_is_int;
  logic [31:0] r_pc;
  logic [2:0]  r_ccr;
  logic        w_idle;
  logic        w_int_req;
  logic        w_req;
  logic        w_int_start;
  logic        w_push;
  logic        w_pop;
  logic        w_push_blk;
  logic        w_pop_blk;
  logic        w_unused;

  assign w_idle      = (r_state == S_IDLE);
  assign w_int_req   = r_pend | interrupt;
  assign w_req       = call | ret | rti | w_int_req;
  assign w_int_start = w_idle & ~call & ~ret & ~rti & w_int_req;
  assign w_push      = (r_state == S_PUSH_H) | (r_state == S_PUSH_L) | (r_state == S_PUSH_C);
  assign w_pop       = (r_state == S_POP_C) | (r_state == S_POP_L) | (r_state == S_POP_H);
  assign w_unused    = &{1'b0, pop_data[15:3]};

`ifdef STACK_GUARD_EN
  logic r_err;

  assign w_push_blk = w_push & (r_sp == 12'h000);
  assign w_pop_blk  = w_pop & (r_sp == SP_RESET);
  assign stack_err  = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_push_blk | w_pop_blk) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_push_blk = 1'b0;
  assign w_pop_blk  = 1'b0;
  assign stack_err  = 1'b0;
`endif

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (call)           w_next = S_PUSH_H;
        else if (ret)       w_next = S_POP_L;
        else if (rti)       w_next = S_POP_C;
        else if (w_int_req) w_next = S_PUSH_H;
        else                w_next = S_IDLE;
      end
      S_PUSH_H: w_next = S_PUSH_L;
      S_PUSH_L: w_next = r_is_int ? S_PUSH_C : S_IDLE;
      S_PUSH_C: w_next = S_VECTOR;
      S_VECTOR: w_next = S_IDLE;
      S_POP_C:  w_next = S_POP_L;
      S_POP_L:  w_next = S_POP_H;
      S_POP_H:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sp     <= SP_RESET;
      r_pend   <= 1'b0;
      r_is_int <= 1'b0;
      r_pc     <= 32'h0;
      r_ccr    <= 3'b0;
    end else begin
      r_state <= w_next;
      // Entering the INT sequence consumes the pending request; otherwise it accumulates.
      r_pend  <= w_int_start ? 1'b0 : (r_pend | interrupt);
      if (w_idle & w_req) begin
        r_pc     <= ret_pc;
        r_ccr    <= ccr_in;
        r_is_int <= w_int_start;
      end
      if (w_push & ~w_push_blk) begin
        r_sp <= r_sp - 12'd1;
      end else if (w_pop & ~w_pop_blk) begin
        r_sp <= r_sp + 12'd1;
      end
    end
  end

  // Pops read the slot above sp; idle cycles simply present sp.
  assign stack_addr      = w_pop ? (r_sp + 12'd1) : r_sp;
  assign stack_we        = w_push & ~w_push_blk;
  assign stack_re        = w_pop & ~w_pop_blk;
  assign pop_pc_low_sig  = (r_state == S_POP_L);
  assign pop_pc_high_sig = (r_state == S_POP_H);
  assign pop_ccr_sig     = (r_state == S_POP_C);
  assign ccr_restore     = pop_ccr_sig ? pop_data[2:0] : 3'b000;
  assign vec_load        = (r_state == S_VECTOR);
  assign busy            = ~w_idle;
  assign fetch_pc_enable = rst | ~(busy | w_req);

  always_comb begin
    stack_wdata = 16'h0000;
    case (r_state)
      S_PUSH_H: stack_wdata = r_pc[31:16];
      S_PUSH_L: stack_wdata = r_pc[15:0];
      S_PUSH_C: stack_wdata = {13'b0, r_ccr};
      default:  stack_wdata = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer (default build): directed scenarios plus random traffic checked
// against a queue-of-bus-operations reference model.
`timescale 1ns/1ps
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic        rti = 1'b0;
  logic        interrupt = 1'b0;
  logic [31:0] ret_pc = 32'h0;
  logic [2:0]  ccr_in = 3'b0;
  logic [15:0] pop_data;
  logic [11:0] stack_addr;
  logic [15:0] stack_wdata;
  logic        stack_we, stack_re, fetch_pc_enable;
  logic        pop_pc_low_sig, pop_pc_high_sig, pop_ccr_sig;
  logic [2:0]  ccr_restore;
  logic        vec_load, busy, stack_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] dev_mem [4096];
  logic [39:0] dut_vec;

  always #5 clk = ~clk;

  stack_sequencer #(.SP_RESET(12'hFFF)) dut (
    .clk(clk), .rst(rst), .call(call), .ret(ret), .rti(rti), .interrupt(interrupt),
    .ret_pc(ret_pc), .ccr_in(ccr_in), .pop_data(pop_data),
    .stack_addr(stack_addr), .stack_wdata(stack_wdata), .stack_we(stack_we), .stack_re(stack_re),
    .fetch_pc_enable(fetch_pc_enable), .pop_pc_low_sig(pop_pc_low_sig),
    .pop_pc_high_sig(pop_pc_high_sig), .pop_ccr_sig(pop_ccr_sig), .ccr_restore(ccr_restore),
    .vec_load(vec_load), .busy(busy), .stack_err(stack_err)
  );

  // Stack memory: combinational read, write on the clock edge.
  assign pop_data = dev_mem[stack_addr];
  always @(posedge clk) if (stack_we) dev_mem[stack_addr] <= stack_wdata;

  assign dut_vec = {busy, fetch_pc_enable, stack_we, stack_re,
                    (stack_we | stack_re) ? stack_addr : 12'h000,
                    stack_we ? stack_wdata : 16'h0000,
                    pop_pc_low_sig, pop_pc_high_sig, pop_ccr_sig, ccr_restore, vec_load, stack_err};

  // Reference model: a queue of pending bus operations plus the stack pointer.
  localparam int K_PUSH = 0, K_POP = 1, K_VEC = 2;
  localparam int SEL_LO = 0, SEL_HI = 1, SEL_CCR = 2;
  typedef struct { int kind; int sel; logic [15:0] data; } op_t;
  op_t         m_q[$];
  logic [11:0] m_sp = 12'hFFF;
  logic        m_pend = 1'b0;

  function automatic logic [39:0] model_expect();
    logic b, f, we, re, pl, ph, pcs, v;
    logic [11:0] a;
    logic [15:0] wd;
    logic [2:0] cr;
    b = 0; f = 1; we = 0; re = 0; pl = 0; ph = 0; pcs = 0; v = 0;
    a = 12'h000; wd = 16'h0000; cr = 3'b000;
    if (rst) begin
      f = 1;
    end else if (m_q.size() == 0) begin
      f = !(call | ret | rti | interrupt | m_pend);
    end else begin
      b = 1; f = 0;
      if (m_q[0].kind == K_PUSH) begin
        we = 1; a = m_sp; wd = m_q[0].data;
      end else if (m_q[0].kind == K_POP) begin
        re = 1; a = m_sp + 12'd1;
        pl = (m_q[0].sel == SEL_LO);
        ph = (m_q[0].sel == SEL_HI);
        pcs = (m_q[0].sel == SEL_CCR);
        if (pcs) cr = dev_mem[a][2:0];
      end else begin
        v = 1;
      end
    end
    return {b, f, we, re, a, wd, pl, ph, pcs, cr, v, 1'b0};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_sp = 12'hFFF;
    m_pend = 1'b0;
  endtask

  task automatic model_step();
    op_t op;
    logic start_int;
    start_int = 1'b0;
    if (m_q.size() != 0) begin
      op = m_q.pop_front();
      if (op.kind == K_PUSH) m_sp = m_sp - 12'd1;
      else if (op.kind == K_POP) m_sp = m_sp + 12'd1;
    end else if (call) begin
      m_q.push_back('{K_PUSH, 0, ret_pc[31:16]});
      m_q.push_back('{K_PUSH, 0, ret_pc[15:0]});
    end else if (ret) begin
      m_q.push_back('{K_POP, SEL_LO, 16'h0});
      m_q.push_back('{K_POP, SEL_HI, 16'h0});
    end else if (rti) begin
      m_q.push_back('{K_POP, SEL_CCR, 16'h0});
      m_q.push_back('{K_POP, SEL_LO, 16'h0});
      m_q.push_back('{K_POP, SEL_HI, 16'h0});
    end else if (m_pend | interrupt) begin
      m_q.push_back('{K_PUSH, 0, ret_pc[31:16]});
      m_q.push_back('{K_PUSH, 0, ret_pc[15:0]});
      m_q.push_back('{K_PUSH, 0, {13'b0, ccr_in}});
      m_q.push_back('{K_VEC, 0, 16'h0});
      start_int = 1'b1;
    end
    m_pend = start_int ? 1'b0 : (m_pend | interrupt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic drive(input logic c, input logic r, input logic t, input logic i,
                       input logic [31:0] pc, input logic [2:0] cc);
    call = c; ret = r; rti = t; interrupt = i; ret_pc = pc; ccr_in = cc;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    model_reset();
    #2;
    n_tests++;
    if ({busy, fetch_pc_enable, stack_we, stack_re, vec_load, stack_err} !== 6'b010000) begin
      n_fail++;
      $display("FAIL reset_async got %b expected 010000",
               {busy, fetch_pc_enable, stack_we, stack_re, vec_load, stack_err});
    end
    @(negedge clk);
    n_tests++;
    if (dut_vec !== model_expect()) begin
      n_fail++; $display("FAIL reset_model got %h expected %h", dut_vec, model_expect());
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_call_ret();
    int lows = 0;
    drive(1, 0, 0, 0, 32'h0001_0020, 3'b000);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== model_expect()) begin
        n_fail++; $display("FAIL call_model c=%0d got %h expected %h", c, dut_vec, model_expect());
      end
      if (!fetch_pc_enable) lows++;
      if (c == 1 || c == 2) begin
        n_tests++;
        if ({stack_we, stack_addr, stack_wdata} !== ((c == 1) ? {1'b1, 12'hFFF, 16'h0001}
                                                              : {1'b1, 12'hFFE, 16'h0020})) begin
          n_fail++; $display("FAIL call_push c=%0d got we=%b addr=%h data=%h", c, stack_we, stack_addr, stack_wdata);
        end
      end
      tick();
      drive(0, 0, 0, 0, 32'h0, 3'b000);
    end
    n_tests++;
    if (lows !== 3) begin
      n_fail++; $display("FAIL call_stall got %0d cycles expected 3", lows);
    end
    drive(0, 1, 0, 0, 32'h0, 3'b000);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== model_expect()) begin
        n_fail++; $display("FAIL ret_model c=%0d got %h expected %h", c, dut_vec, model_expect());
      end
      if (c == 1 || c == 2) begin
        n_tests++;
        if ({stack_re, pop_pc_low_sig, pop_pc_high_sig, stack_addr, pop_data} !==
            ((c == 1) ? {3'b110, 12'hFFE, 16'h0020} : {3'b101, 12'hFFF, 16'h0001})) begin
          n_fail++; $display("FAIL ret_pop c=%0d got re=%b lo=%b hi=%b addr=%h data=%h",
                             c, stack_re, pop_pc_low_sig, pop_pc_high_sig, stack_addr, pop_data);
        end
      end
      tick();
      drive(0, 0, 0, 0, 32'h0, 3'b000);
    end
  endtask

  task automatic test_interrupt_rti();
    drive(0, 0, 0, 1, 32'h0000_0105, 3'b101);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== model_expect()) begin
        n_fail++; $display("FAIL int_model c=%0d got %h expected %h", c, dut_vec, model_expect());
      end
      if (c >= 1 && c <= 3) begin
        n_tests++;
        if ({stack_we, stack_addr, stack_wdata} !==
            ((c == 1) ? {1'b1, 12'hFFF, 16'h0000} :
             (c == 2) ? {1'b1, 12'hFFE, 16'h0105} : {1'b1, 12'hFFD, 16'h0005})) begin
          n_fail++; $display("FAIL int_push c=%0d got we=%b addr=%h data=%h", c, stack_we, stack_addr, stack_wdata);
        end
      end
      n_tests++;
      if (vec_load !== (c == 4)) begin
        n_fail++; $display("FAIL int_vec c=%0d got %b expected %b", c, vec_load, (c == 4));
      end
      tick();
      drive(0, 0, 0, 0, 32'h0, 3'b000);
    end
    drive(0, 0, 1, 0, 32'h0, 3'b010);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== model_expect()) begin
        n_fail++; $display("FAIL rti_model c=%0d got %h expected %h", c, dut_vec, model_expect());
      end
      if (c == 1) begin
        n_tests++;
        if ({pop_ccr_sig, stack_re, stack_addr, ccr_restore} !== {2'b11, 12'hFFD, 3'b101}) begin
          n_fail++; $display("FAIL rti_ccr got sig=%b re=%b addr=%h ccr=%b expected 1 1 ffd 101",
                             pop_ccr_sig, stack_re, stack_addr, ccr_restore);
        end
      end
      tick();
      drive(0, 0, 0, 0, 32'h0, 3'b000);
    end
  endtask

  task automatic test_call_int_same();
    drive(1, 0, 0, 1, 32'h1234_5678, 3'b011);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== model_expect()) begin
        n_fail++; $display("FAIL callint_model c=%0d got %h expected %h", c, dut_vec, model_expect());
      end
      if (c == 1) begin
        n_tests++;
        if ({stack_we, stack_addr, stack_wdata} !== {1'b1, 12'hFFF, 16'h1234}) begin
          n_fail++; $display("FAIL callint_first got we=%b addr=%h data=%h expected call push", stack_we, stack_addr, stack_wdata);
        end
      end
      if (c == 3) begin
        n_tests++;
        if ({busy, fetch_pc_enable} !== 2'b00) begin
          n_fail++; $display("FAIL callint_pending got busy=%b fetch=%b expected 0 0", busy, fetch_pc_enable);
        end
      end
      if (c == 7) begin
        n_tests++;
        if (vec_load !== 1'b1) begin
          n_fail++; $display("FAIL callint_vec got %b expected 1", vec_load);
        end
      end
      tick();
      drive(0, 0, 0, 0, 32'h0, 3'b000);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 32'hCAFE_BEEF, 3'b000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== model_expect()) begin
        n_fail++; $display("FAIL rstmid_model c=%0d got %h expected %h", c, dut_vec, model_expect());
      end
      if (c < 2) begin
        tick();
        drive(0, 0, 0, 0, 32'h0, 3'b000);
      end
    end
    #1 rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if ({busy, stack_we, fetch_pc_enable} !== 3'b001) begin
      n_fail++; $display("FAIL rstmid_now got busy=%b we=%b fetch=%b expected 0 0 1", busy, stack_we, fetch_pc_enable);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({busy, stack_we, stack_re} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_hold got busy=%b we=%b re=%b expected 000", busy, stack_we, stack_re);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    drive(0, 1, 0, 0, 32'h0, 3'b000);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== model_expect()) begin
        n_fail++; $display("FAIL wrap_model c=%0d got %h expected %h", c, dut_vec, model_expect());
      end
      if (c == 1 || c == 2) begin
        n_tests++;
        if ({stack_re, stack_addr, stack_err} !== {1'b1, (c == 1) ? 12'h000 : 12'h001, 1'b0}) begin
          n_fail++; $display("FAIL wrap_pop c=%0d got re=%b addr=%h err=%b", c, stack_re, stack_addr, stack_err);
        end
      end
      tick();
      drive(0, 0, 0, 0, 32'h0, 3'b000);
    end
    drive(1, 0, 0, 0, 32'hA5A5_5A5A, 3'b000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== model_expect()) begin
        n_fail++; $display("FAIL wrap_call_model c=%0d got %h expected %h", c, dut_vec, model_expect());
      end
      if (c == 1) begin
        n_tests++;
        if ({stack_we, stack_addr} !== {1'b1, 12'h001}) begin
          n_fail++; $display("FAIL wrap_sp got we=%b addr=%h expected 1 001", stack_we, stack_addr);
        end
      end
      tick();
      drive(0, 0, 0, 0, 32'h0, 3'b000);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 6, $urandom, 3'($urandom_range(0, 7)));
      @(negedge clk);
      n_tests++;
      if (dut_vec !== model_expect()) begin
        n_fail++; $display("FAIL random_model n=%0d got %h expected %h", n, dut_vec, model_expect());
      end
      tick();
    end
    drive(0, 0, 0, 0, 32'h0, 3'b000);
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_interrupt_rti();
    test_call_int_same();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameter: SP_RESET, default 12'hFFF, stack pointer value loaded on reset.
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: call, ret, rti  input  1 each  one-cycle request pulses from decode.
REQ-005 Port: interrupt  input  1  level interrupt request.
REQ-006 Port: ret_pc  input  32  return address, sampled at sequence start.
REQ-007 Port: ccr_in  input  3  flags, sampled at sequence start.
REQ-008 Port: pop_data  input  16  stack read data, valid in the same cycle as stack_re (combinational memory read).
REQ-009 Port: stack_addr  output  12  memory address for the current stack access.
REQ-010 Port: stack_wdata  output  16  push data.
REQ-011 Port: stack_we, stack_re  output  1 each  push and pop strobes.
REQ-012 Port: fetch_pc_enable  output  1  low while fetch is stalled.
REQ-013 Port: pop_pc_low_sig, pop_pc_high_sig, pop_ccr_sig  output  1 each  pop_data carries PC[15:0], PC[31:16] or CCR this cycle.
REQ-014 Port: ccr_restore  output  3  pop_data[2:0] while pop_ccr_sig is high, else 0.
REQ-015 Port: vec_load  output  1  one-cycle pulse; PC loads the interrupt vector.
REQ-016 Port: busy  output  1  high when state is not IDLE.
REQ-017 Port: stack_err  output  1  sticky stack guard error (see Configuration).

Function
REQ-018 States SHALL be IDLE, PUSH_H, PUSH_L, PUSH_C, VECTOR, POP_C, POP_L, POP_H; encoding is free.
REQ-019 The sequences SHALL be:
- CALL: IDLE->PUSH_H->PUSH_L->IDLE.
- INT: IDLE->PUSH_H->PUSH_L->PUSH_C->VECTOR->IDLE.
- RET: IDLE->POP_L->POP_H->IDLE.
- RTI: IDLE->POP_C->POP_L->POP_H->IDLE.
REQ-020 At the IDLE edge where a request is seen, ret_pc and ccr_in SHALL be latched; pushes SHALL use the latched values.
REQ-021 Push cycle: stack_we=1, stack_addr=sp, then sp<=sp-1.
- PUSH_H writes PC[31:16].
- PUSH_L writes PC[15:0].
- PUSH_C writes {13'b0,ccr}.
REQ-022 Pop cycle: stack_re=1, stack_addr=sp+1, sp<=sp+1, and the matching pop_*_sig=1.
REQ-023 Priority in IDLE: call > ret > rti > pending interrupt; at most one sequence starts per cycle.
REQ-024 An interrupt high in any cycle SHALL set a pending flag.
- The pending flag is cleared on entry to PUSH_H of the INT sequence.
- An interrupt arriving mid-sequence is served on the first IDLE cycle after that sequence.
REQ-025 call/ret/rti pulses while busy SHALL be ignored.
REQ-026 fetch_pc_enable = 0 when busy, or when in IDLE with any request or pending interrupt; otherwise 1.
REQ-027 Every strobe (stack_we, stack_re, pop_*_sig, vec_load) SHALL be a decode of the current state; at most one stack strobe is high per cycle.
REQ-028 sp SHALL be 12 bits; arithmetic is modulo 4096 unless guarded.

Reset
REQ-029 rst high SHALL, without waiting for clk:
- force state=IDLE, sp=SP_RESET, pending=0, latches=0, stack_err=0;
- drive all strobes to 0, fetch_pc_enable=1, busy=0.
REQ-030 Reset mid-sequence SHALL abandon the sequence with no further stack access.

Configuration
REQ-031 Macro STACK_GUARD_EN, when defined:
- a push at sp==0 or a pop at sp==SP_RESET sets stack_err sticky until reset;
- the offending stack_we/stack_re is suppressed and sp is held;
- the sequence still advances.
REQ-032 Macro STACK_GUARD_EN, when undefined: sp wraps modulo 4096 and stack_err is tied to 0.

Verification
REQ-033 Reset, then call=1 with ret_pc=32'h0001_0020:
- pushes 16'h0001 @FFF, then 16'h0020 @FFE;
- sp=FFD;
- fetch_pc_enable low for 3 cycles.
REQ-034 Following REQ-033, ret=1 with memory returning 16'h0020, 16'h0001:
- pop_pc_low_sig is high at address FFE, then pop_pc_high_sig at FFF;
- sp=FFF.
REQ-035 Interrupt with ret_pc=32'h0000_0105, ccr_in=3'b101:
- pushes 0000, 0105, 0005 at FFF, FFE, FFD;
- vec_load pulses in cycle 5;
- RTI then restores ccr_restore=3'b101.
REQ-036 call and interrupt in the same cycle:
- the CALL sequence completes first;
- the INT sequence starts on the next IDLE cycle;
- the pending interrupt is not lost.
REQ-037 rst asserted during PUSH_L:
- no further stack_we;
- sp=FFF and busy=0 immediately.
REQ-038 STACK_GUARD_EN defined, ret issued at sp=FFF:
- stack_re is suppressed and stack_err=1;
- with the macro undefined, sp wraps to 000 and then 001.
